// File: rtl/sim8051_rom_loader_if.sv
// Host byte channel plus ROM word-write port of the ROM loader.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready throttles the byte channel; the ROM write port has none.
interface sim8051_rom_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  // Host / testbench side: drives bytes, observes the ROM writes.
  modport master (
    output in_valid, in_data,
    input  in_ready, wr, wr_addr, wr_data
  );

  // Loader side: consumes bytes, issues ROM writes.
  modport slave (
    input  in_valid, in_data,
    output in_ready, wr, wr_addr, wr_data
  );
endinterface

// File: rtl/sim8051_rom_loader.sv
// Parses SYNC/ADDR/LEN/payload/CSUM frames and packs payload into 32-bit LE ROM word writes.
// Latency: wr pulses the cycle after the byte that completes a word; done/err one cycle after CSUM.
// Backpressure: in_ready drops only for the single response cycle; ROM writes are never stalled.
module sim8051_rom_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] PAD_BYTE  = 8'h00,
  parameter int         TIMEOUT   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  sim8051_rom_loader_if.slave        bus,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [1:0]                 err_code_o
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] TO_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_RESP} state_t;

  state_t      state_q;
  logic [1:0]  hdr_cnt_q;
  logic [15:0] addr_q;      // address of the word currently being assembled
  logic [15:0] len_q;       // payload bytes still to come
  logic [1:0]  lane_q;
  logic [31:0] buf_q;       // partial word, unused lanes pre-filled with PAD_BYTE
  logic [7:0]  sum_q;
  logic [IW-1:0] idle_q;
  logic        rdy_q;
  logic        wr_q;
  logic [15:0] wr_addr_q;
  logic [31:0] wr_data_q;
  logic        done_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  logic        accept;
  logic        active;
  logic        timeout_hit;
  logic [31:0] word_d;
  logic [7:0]  sum_d;

  assign accept      = bus.in_valid & rdy_q;
  assign active      = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign timeout_hit = (TIMEOUT != 0) && active && !accept && (idle_q == TO_LAST);
  assign sum_d       = sum_q + bus.in_data;

  // Current partial word with the incoming byte dropped into its lane.
  always_comb begin
    word_d = buf_q;
    word_d[{lane_q, 3'b000} +: 8] = bus.in_data;
  end

  // Frame parser, word packer, response and idle-timeout handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hdr_cnt_q  <= 2'd0;
      addr_q     <= 16'd0;
      len_q      <= 16'd0;
      lane_q     <= 2'd0;
      buf_q      <= {4{PAD_BYTE}};
      sum_q      <= 8'd0;
      idle_q     <= '0;
      rdy_q      <= 1'b1;
      wr_q       <= 1'b0;
      wr_addr_q  <= 16'd0;
      wr_data_q  <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept && bus.in_data == SYNC_BYTE) begin
            state_q   <= S_HDR;
            hdr_cnt_q <= 2'd0;
            sum_q     <= 8'd0;
            idle_q    <= '0;
          end
        end
        S_HDR: begin
          if (accept) begin
            sum_q     <= sum_d;
            idle_q    <= '0;
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            case (hdr_cnt_q)
              2'd0: addr_q[15:8] <= bus.in_data;
              2'd1: addr_q[7:0]  <= bus.in_data;
              2'd2: len_q[15:8]  <= bus.in_data;
              default: begin
                len_q[7:0] <= bus.in_data;
                lane_q     <= 2'd0;
                buf_q      <= {4{PAD_BYTE}};
                state_q    <= ({len_q[15:8], bus.in_data} == 16'd0) ? S_CSUM : S_DATA;
              end
            endcase
          end
        end
        S_DATA: begin
          if (accept) begin
            sum_q  <= sum_d;
            idle_q <= '0;
            len_q  <= len_q - 16'd1;
            if (lane_q == 2'd3 || len_q == 16'd1) begin
              wr_q      <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= word_d;
              addr_q    <= addr_q + 16'd4;
              buf_q     <= {4{PAD_BYTE}};
              lane_q    <= 2'd0;
            end else begin
              buf_q  <= word_d;
              lane_q <= lane_q + 2'd1;
            end
            if (len_q == 16'd1) state_q <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (accept) begin
            state_q <= S_RESP;
            rdy_q   <= 1'b0;
            if (sum_d == 8'd0) begin
              done_q <= 1'b1;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= 2'b01;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
      // Idle cycles mid-frame; an accepted byte in the same cycle always wins.
      if (active && !accept) begin
        if (timeout_hit) begin
          state_q    <= S_IDLE;
          err_q      <= 1'b1;
          err_code_q <= 2'b10;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = rdy_q;
  assign bus.wr       = wr_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_sim8051_rom_loader.sv
// Bench for the ROM loader: frame-level reference model checked every cycle, plus literal frame checks.
// Latency: model predicts each output one cycle after the accepting edge.
// Backpressure: driver holds a byte until in_ready lets it through.
module tb_sim8051_rom_loader;
  localparam int         TO   = 32;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] PAD  = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, done, err;
  logic [1:0] err_code;

  sim8051_rom_loader_if bus ();

  sim8051_rom_loader #(.SYNC_BYTE(SYNC), .PAD_BYTE(PAD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic        e_rdy = 1'b1, e_busy = 1'b0, e_wr = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [15:0] e_addr = 16'd0;
  logic [31:0] e_data = 32'd0;
  logic [1:0]  e_code = 2'd0;
  bit          m_in_frame = 0, m_resp = 0, chk_en = 0;
  int          m_idle = 0;
  logic [7:0]  mq[$];

  task automatic model_step();
    bit acc;
    int n, len, idx, w, s;
    logic [7:0] b;
    acc = bus.in_valid && e_rdy;
    e_wr = 0; e_done = 0; e_err = 0;
    if (rst) begin
      m_in_frame = 0; m_resp = 0; m_idle = 0; mq.delete();
      e_addr = 16'd0; e_data = 32'd0; e_code = 2'd0;
      chk_en = 1;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (!m_in_frame) begin
      if (acc && bus.in_data == SYNC) begin
        m_in_frame = 1; mq.delete(); m_idle = 0;
      end
    end else if (acc) begin
      m_idle = 0;
      mq.push_back(bus.in_data);
      n = mq.size();
      len = (n >= 4) ? int'({mq[2], mq[3]}) : 0;
      if (n >= 5 && n <= 4 + len) begin
        idx = n - 5;
        if (idx % 4 == 3 || idx == len - 1) begin
          w = idx / 4;
          e_wr = 1;
          e_addr = {mq[0], mq[1]} + 16'(4 * w);
          for (int k = 0; k < 4; k++) begin
            b = (4 * w + k <= idx) ? mq[4 + 4 * w + k] : PAD;
            e_data[8*k +: 8] = b;
          end
        end
      end
      if (n >= 5 && n == 5 + len) begin
        s = 0;
        foreach (mq[i]) s += mq[i];
        if (s % 256 == 0) e_done = 1;
        else begin e_err = 1; e_code = 2'b01; end
        m_in_frame = 0; m_resp = 1;
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        e_err = 1; e_code = 2'b10; m_in_frame = 0;
      end
    end
    e_rdy  = !m_resp;
    e_busy = m_in_frame || m_resp;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare + event log ----------------
  logic [15:0] wl_addr[$];
  logic [31:0] wl_data[$];
  int done_cnt = 0, err_cnt = 0;
  logic [1:0] last_code = 2'd0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready", bus.in_ready, e_rdy);
      chk("busy", busy, e_busy);
      chk("wr", bus.wr, e_wr);
      chk("wr_addr", bus.wr_addr, e_addr);
      chk("wr_data", bus.wr_data, e_data);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("err_code", err_code, e_code);
      if (bus.wr === 1'b1) begin wl_addr.push_back(bus.wr_addr); wl_data.push_back(bus.wr_data); end
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) begin err_cnt++; last_code = err_code; end
    end
  end

  // ---------------- driver ----------------
  logic [7:0] pay[64];

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_byte(input logic [7:0] b);
    bit r;
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    forever begin
      r = bus.in_ready;
      @(negedge clk);
      if (r) break;
      t++;
      if (t > 50) begin
        errors++;
        $display("FAIL put_byte: in_ready stuck low, got 0 expected 1");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic put_gap(input logic [7:0] b, input int maxgap);
    put_byte(b);
    if (maxgap > 0) idle($urandom_range(0, maxgap));
  endtask

  // csum_ovr < 0 means a correct checksum; otherwise the given byte is sent.
  task automatic send_frame(input logic [15:0] a, input int len, input int csum_ovr, input int maxgap);
    logic [7:0] s;
    s = a[15:8] + a[7:0] + 8'(len >> 8) + 8'(len);
    for (int i = 0; i < len; i++) s += pay[i];
    put_gap(SYNC, maxgap);
    put_gap(a[15:8], maxgap);
    put_gap(a[7:0], maxgap);
    put_gap(8'(len >> 8), maxgap);
    put_gap(8'(len), maxgap);
    for (int i = 0; i < len; i++) put_gap(pay[i], maxgap);
    put_byte((csum_ovr < 0) ? 8'(-s) : 8'(csum_ovr));
    idle(3);
  endtask

  task automatic set_f1();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
  endtask

  task automatic f1_expect(input string tag, input int w0, input int d0, input int e0);
    chk({tag, "_nwr"}, wl_addr.size() - w0, 1);
    if (wl_addr.size() > w0) begin
      chk({tag, "_addr"}, wl_addr[w0], 32'h0100);
      chk({tag, "_data"}, wl_data[w0], 32'h44332211);
    end
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_err"}, err_cnt - e0, 0);
  endtask

  initial begin
    int w0, d0, e0, len;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    idle(2);

    // Frame 1: single word
    w0 = wl_addr.size(); d0 = done_cnt; e0 = err_cnt;
    set_f1(); send_frame(16'h0100, 4, -1, 0);
    f1_expect("f1", w0, d0, e0);

    // Frame 2: partial final word padded
    w0 = wl_addr.size(); d0 = done_cnt;
    set_f1(); pay[4] = 8'h55; send_frame(16'h0100, 5, -1, 0);
    chk("f2_nwr", wl_addr.size() - w0, 2);
    if (wl_addr.size() >= w0 + 2) begin
      chk("f2_data0", wl_data[w0], 32'h44332211);
      chk("f2_addr1", wl_addr[w0+1], 32'h0104);
      chk("f2_data1", wl_data[w0+1], 32'h00000055);
    end
    chk("f2_done", done_cnt - d0, 1);

    // Frame 3: address wrap
    w0 = wl_addr.size();
    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    send_frame(16'hFFFC, 8, -1, 0);
    chk("f3_nwr", wl_addr.size() - w0, 2);
    if (wl_addr.size() >= w0 + 2) begin
      chk("f3_addr0", wl_addr[w0], 32'hFFFC);
      chk("f3_data0", wl_data[w0], 32'h04030201);
      chk("f3_addr1", wl_addr[w0+1], 32'h0000);
      chk("f3_data1", wl_data[w0+1], 32'h08070605);
    end

    // Frame 4: bad checksum still writes
    w0 = wl_addr.size(); d0 = done_cnt; e0 = err_cnt;
    set_f1(); send_frame(16'h0100, 4, 8'h50, 0);
    chk("f4_nwr", wl_addr.size() - w0, 1);
    chk("f4_err", err_cnt - e0, 1);
    chk("f4_code", last_code, 2'b01);
    chk("f4_done", done_cnt - d0, 0);

    // Timeout after two payload bytes, then a good frame
    w0 = wl_addr.size(); e0 = err_cnt;
    put_byte(SYNC); put_byte(8'h01); put_byte(8'h00); put_byte(8'h00);
    put_byte(8'h04); put_byte(8'h11); put_byte(8'h22);
    idle(TO + 5);
    chk("to_nwr", wl_addr.size() - w0, 0);
    chk("to_err", err_cnt - e0, 1);
    chk("to_code", last_code, 2'b10);
    chk("to_busy", busy, 0);
    w0 = wl_addr.size(); d0 = done_cnt; e0 = err_cnt;
    set_f1(); send_frame(16'h0100, 4, -1, 0);
    f1_expect("to_next", w0, d0, e0);

    // Garbage before SYNC and gaps between bytes
    w0 = wl_addr.size(); d0 = done_cnt; e0 = err_cnt;
    put_gap(8'h00, 2); put_gap(8'hFF, 1); put_gap(8'h5A, 2);
    set_f1(); send_frame(16'h0100, 4, -1, 3);
    f1_expect("garb", w0, d0, e0);

    // Same stimulus with reset mid-DATA
    w0 = wl_addr.size(); d0 = done_cnt; e0 = err_cnt;
    put_gap(8'h00, 2); put_gap(8'hFF, 1); put_gap(8'h5A, 2);
    put_gap(SYNC, 1); put_gap(8'h01, 0); put_gap(8'h00, 2); put_gap(8'h00, 0);
    put_gap(8'h04, 1); put_gap(8'h11, 0); put_byte(8'h22);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    idle(TO + 5);
    chk("rstmid_nwr", wl_addr.size() - w0, 0);
    chk("rstmid_done", done_cnt - d0, 0);
    chk("rstmid_err", err_cnt - e0, 0);

    // LEN == 0 goes straight to checksum
    w0 = wl_addr.size(); d0 = done_cnt;
    send_frame(16'h1234, 0, -1, 0);
    chk("len0_nwr", wl_addr.size() - w0, 0);
    chk("len0_done", done_cnt - d0, 1);

    // Randomized frames against the model
    for (int f = 0; f < 40; f++) begin
      int ng;
      ng = $urandom_range(0, 3);
      for (int g = 0; g < ng; g++) begin
        logic [7:0] gb;
        gb = 8'($urandom);
        if (gb == SYNC) gb = 8'h00;
        put_gap(gb, 1);
      end
      len = $urandom_range(0, 13);
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      send_frame(16'($urandom), len, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : -1, 2);
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
